// File: rtl/g3f_pkg.sv
// g3f_pkg: shared definitions for the three-phase sequencer.
//   g3f_state_e  : sequencer FSM states (IDLE / DEAD / RUN / STOPPING)
//   STEP_N       : number of commutation steps per revolution
//   step_pattern : step index -> {qa,qb,qc} commutation pattern
//   next_step    : step index advanced by one in the selected direction, with wrap
package g3f_pkg;

   localparam int STEP_N = 6;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEAD     = 2'd1,
      ST_RUN      = 2'd2,
      ST_STOPPING = 2'd3
   } g3f_state_e;

   // Six-step table; neighbouring entries differ in exactly one phase.
   function automatic logic [2:0] step_pattern(input logic [2:0] step);
      logic [2:0] pat;
      case (step)
         3'd0:    pat = 3'b100;
         3'd1:    pat = 3'b110;
         3'd2:    pat = 3'b010;
         3'd3:    pat = 3'b011;
         3'd4:    pat = 3'b001;
         3'd5:    pat = 3'b101;
         default: pat = 3'b000;
      endcase
      return pat;
   endfunction

   // dir = 1 counts up (5 wraps to 0), dir = 0 counts down (0 wraps to 5).
   function automatic logic [2:0] next_step(input logic [2:0] step, input logic dir);
      logic [2:0] nxt;
      if (dir) begin
         nxt = (step == 3'(STEP_N - 1)) ? 3'd0 : step + 3'd1;
      end else begin
         nxt = (step == 3'd0) ? 3'(STEP_N - 1) : step - 3'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/g3f_phase_sequencer_deadtime.sv
// g3f_deadtime: rising-edge delay for one phase output.
//   clk, rst  : clock, synchronous active-high reset
//   clr_i     : synchronous clear (kill), output forced low
//   bound_i   : a step boundary happens on this edge; ends any pending delay
//   din_i     : phase value the output should take on the next clock
//   dl_i      : dead-time in clocks for rising edges
//   q_o       : registered phase output
// A rise of din_i keeps q_o low for dl_i clocks; a fall reaches q_o at once.
// The delay never reaches into the following step: if the step ends first,
// the phase comes up with the first clock of the new step.
module g3f_deadtime #(
   parameter int DEAD_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              bound_i,
   input  logic              din_i,
   input  logic [DEAD_W-1:0] dl_i,
   output logic              q_o
);

   logic              q_q, q_d;
   logic              prev_q, prev_d;
   logic [DEAD_W-1:0] cnt_q, cnt_d;

   always_comb begin
      q_d    = q_q;
      prev_d = din_i;
      cnt_d  = cnt_q;
      if (clr_i) begin
         q_d    = 1'b0;
         prev_d = 1'b0;
         cnt_d  = '0;
      end else if (din_i && !prev_q) begin
         // New rising edge: the first low clock is the one being entered,
         // so dl_i-1 more low clocks remain after it.
         if (dl_i == '0) begin
            q_d   = 1'b1;
            cnt_d = '0;
         end else begin
            q_d   = 1'b0;
            cnt_d = dl_i - DEAD_W'(1);
         end
      end else if (!din_i) begin
         q_d   = 1'b0;
         cnt_d = '0;
      end else if (bound_i) begin
         q_d   = 1'b1;
         cnt_d = '0;
      end else if (cnt_q != '0) begin
         q_d   = 1'b0;
         cnt_d = cnt_q - DEAD_W'(1);
      end else begin
         q_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q    <= 1'b0;
         prev_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         q_q    <= q_d;
         prev_q <= prev_d;
         cnt_q  <= cnt_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/g3f_phase_sequencer.sv
// g3f_phase_sequencer: six-step three-phase commutation sequencer.
//   clk, rst        : clock, synchronous active-high reset
//   en_i            : global enable, low kills everything on the next clock
//   start_i, stop_i : one-clock start pulse / graceful stop request
//   dir_i           : 1 = forward (step+1), 0 = reverse (step-1), sampled at step ends
//   period_i        : clocks per step minus one (0 behaves as 1), sampled at start and step ends
//   dead_i          : rising-edge dead-time in clocks, sampled at start
//   qa_o,qb_o,qc_o  : registered phase outputs
//   step_o          : current step index 0..5
//   busy_o          : high whenever the sequencer is not idle
//   sync_o          : one-clock pulse when a running step wraps into step 0
module g3f_phase_sequencer
   import g3f_pkg::*;
#(
   parameter int DIV_W  = 16,
   parameter int DEAD_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_i,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic              dir_i,
   input  logic [DIV_W-1:0]  period_i,
   input  logic [DEAD_W-1:0] dead_i,
   output logic              qa_o,
   output logic              qb_o,
   output logic              qc_o,
   output logic [2:0]        step_o,
   output logic              busy_o,
   output logic              sync_o
);

   g3f_state_e        state_q, state_d;
   logic [2:0]        step_q, step_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [DIV_W-1:0]  pl_q, pl_d;
   logic [DEAD_W-1:0] dl_q, dl_d;
   logic              sync_q, sync_d;

   logic [DIV_W-1:0]  period_clamped;
   logic              step_end;
   logic              dead_last;
   logic [2:0]        nstep;
   logic              rise_next;
   logic              advance;
   logic [2:0]        pat_d;

   assign period_clamped = (period_i == '0) ? DIV_W'(1) : period_i;
   assign step_end       = (cnt_q == pl_q);
   // Last held-low clock of the dead window; only meaningful in DEAD, where dl_q > 0.
   assign dead_last      = (cnt_q == (DIV_W'(dl_q) - DIV_W'(1)));
   assign nstep          = next_step(step_q, dir_i);
   assign rise_next      = |(step_pattern(nstep) & ~step_pattern(step_q));

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      cnt_d   = cnt_q;
      pl_d    = pl_q;
      dl_d    = dl_q;
      sync_d  = 1'b0;
      advance = 1'b0;

      case (state_q)
         ST_IDLE: begin
            step_d = 3'd0;
            cnt_d  = '0;
            if (start_i && !stop_i) begin
               pl_d    = period_clamped;
               dl_d    = dead_i;
               state_d = (dead_i != '0) ? ST_DEAD : ST_RUN;
            end
         end
         ST_DEAD, ST_RUN: begin
            if (step_end) begin
               cnt_d = '0;
               if (stop_i) begin
                  state_d = ST_IDLE;
                  step_d  = 3'd0;
               end else begin
                  advance = 1'b1;
                  step_d  = nstep;
                  pl_d    = period_clamped;
                  sync_d  = (nstep == 3'd0);
                  state_d = (rise_next && (dl_q != '0)) ? ST_DEAD : ST_RUN;
               end
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
               if (stop_i) begin
                  state_d = ST_STOPPING;
               end else if ((state_q == ST_DEAD) && dead_last) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_STOPPING: begin
            if (step_end) begin
               state_d = ST_IDLE;
               step_d  = 3'd0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            step_d  = 3'd0;
            cnt_d   = '0;
         end
      endcase

      // Kill overrides every request and clears all counters.
      if (!en_i) begin
         state_d = ST_IDLE;
         step_d  = 3'd0;
         cnt_d   = '0;
         pl_d    = '0;
         dl_d    = '0;
         sync_d  = 1'b0;
         advance = 1'b0;
      end

      pat_d = (state_d != ST_IDLE) ? step_pattern(step_d) : 3'b000;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         step_q  <= 3'd0;
         cnt_q   <= '0;
         pl_q    <= '0;
         dl_q    <= '0;
         sync_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         pl_q    <= pl_d;
         dl_q    <= dl_d;
         sync_q  <= sync_d;
      end
   end

   // dl_d is used so the very first rise after start sees the freshly latched dead-time.
   g3f_deadtime #(.DEAD_W(DEAD_W)) u_dt_a (
      .clk(clk), .rst(rst), .clr_i(!en_i), .bound_i(advance),
      .din_i(pat_d[2]), .dl_i(dl_d), .q_o(qa_o)
   );
   g3f_deadtime #(.DEAD_W(DEAD_W)) u_dt_b (
      .clk(clk), .rst(rst), .clr_i(!en_i), .bound_i(advance),
      .din_i(pat_d[1]), .dl_i(dl_d), .q_o(qb_o)
   );
   g3f_deadtime #(.DEAD_W(DEAD_W)) u_dt_c (
      .clk(clk), .rst(rst), .clr_i(!en_i), .bound_i(advance),
      .din_i(pat_d[0]), .dl_i(dl_d), .q_o(qc_o)
   );

   assign step_o = step_q;
   assign busy_o = (state_q != ST_IDLE);
   assign sync_o = sync_q;

endmodule

// File: tb/tb_g3f_phase_sequencer.sv
// Testbench for g3f_phase_sequencer: reference model of the commutation rules,
// per-cycle expected vectors in exp_q, one task per scenario.
module tb_g3f_phase_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        en_i;
   logic        start_i;
   logic        stop_i;
   logic        dir_i;
   logic [15:0] period_i;
   logic [3:0]  dead_i;
   logic        qa_o, qb_o, qc_o;
   logic [2:0]  step_o;
   logic        busy_o;
   logic        sync_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // observed/expected vector: {qa,qb,qc,step[2:0],busy,sync}
   logic [7:0] exp_q[$];
   logic [7:0] exp_v;
   wire  [7:0] obs = {qa_o, qb_o, qc_o, step_o, busy_o, sync_o};

   g3f_phase_sequencer #(.DIV_W(16), .DEAD_W(4)) dut (
      .clk(clk), .rst(rst), .en_i(en_i), .start_i(start_i), .stop_i(stop_i),
      .dir_i(dir_i), .period_i(period_i), .dead_i(dead_i),
      .qa_o(qa_o), .qb_o(qb_o), .qc_o(qc_o), .step_o(step_o),
      .busy_o(busy_o), .sync_o(sync_o)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Running state is described as (step, time within step); the rising phase
   // of a step is masked while time < dead-time.
   int pat_tbl[6] = '{4, 6, 2, 3, 1, 5};
   int m_run = 0, m_step = 0, m_t = 0, m_pl = 1, m_dl = 0, m_prev = 0;
   int m_stopping = 0, m_sync = 0;

   always @(posedge clk) begin
      int p, rise;
      m_sync = 0;
      if (rst || !en_i) begin
         m_run = 0; m_step = 0; m_t = 0; m_stopping = 0; m_prev = 0;
      end else if (m_run == 0) begin
         if (start_i && !stop_i) begin
            m_run = 1; m_step = 0; m_t = 0; m_prev = 0; m_stopping = 0;
            m_pl = (period_i == 0) ? 1 : int'(period_i);
            m_dl = int'(dead_i);
         end
      end else if (m_t == m_pl) begin
         if (m_stopping != 0 || stop_i) begin
            m_run = 0; m_step = 0; m_t = 0; m_stopping = 0;
         end else begin
            m_prev = pat_tbl[m_step];
            m_step = dir_i ? (m_step + 1) % 6 : (m_step + 5) % 6;
            m_sync = (m_step == 0) ? 1 : 0;
            m_t    = 0;
            m_pl   = (period_i == 0) ? 1 : int'(period_i);
         end
      end else begin
         m_t = m_t + 1;
         if (stop_i) m_stopping = 1;
      end
      p = 0;
      if (m_run != 0) begin
         p    = pat_tbl[m_step];
         rise = p & ~m_prev;
         if (m_t < m_dl) p = p & ~rise;
      end
      exp_q.push_back({p[2:0], m_step[2:0], m_run[0], m_sync[0]});
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) exp_v = 'x;
      else exp_v = exp_q.pop_front();
      cyc++;
   endtask

   task automatic kill();
      start_i = 0; stop_i = 0; en_i = 0;
      tick();
      checks++;
      if (obs !== 8'h00) begin
         errors++;
         $display("FAIL kill cyc=%0d got=%b exp=%b", cyc, obs, 8'h00);
      end
      en_i = 1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1; en_i = 0; start_i = 0; stop_i = 0; dir_i = 1; period_i = 3; dead_i = 0;
      repeat (3) tick();
      checks++;
      if (obs !== 8'h00) begin
         errors++;
         $display("FAIL reset_state got=%b exp=%b", obs, 8'h00);
      end
      rst = 0; en_i = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (obs !== 8'h00 || obs !== exp_v) begin
            errors++;
            $display("FAIL idle_no_start cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
      end
   endtask

   task automatic test_forward();
      int last_sync = -1, nsync = 0;
      period_i = 3; dead_i = 0; dir_i = 1; start_i = 1;
      for (int i = 0; i <= 60; i++) begin
         tick();
         start_i = 0;
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL forward cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
         if (sync_o === 1'b1) begin
            if (last_sync >= 0) begin
               checks++;
               if (i - last_sync != 24) begin
                  errors++;
                  $display("FAIL sync_interval got=%0d exp=24", i - last_sync);
               end
            end
            last_sync = i;
            nsync++;
         end
      end
      checks++;
      if (nsync != 2) begin
         errors++;
         $display("FAIL sync_count got=%0d exp=2", nsync);
      end
      kill();
   endtask

   task automatic test_deadtime();
      int s1 = -1, rq = -1, s2 = -1;
      period_i = 9; dead_i = 2; dir_i = 1; start_i = 1;
      for (int i = 0; i < 40; i++) begin
         tick();
         start_i = 0;
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL deadtime cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
         if (step_o == 3'd1 && s1 < 0) s1 = i;
         if (s1 >= 0 && qb_o === 1'b1 && rq < 0) rq = i;
         if (step_o == 3'd2 && s2 < 0) begin
            s2 = i;
            checks++;
            if (qa_o !== 1'b0) begin
               errors++;
               $display("FAIL qa_fall_immediate got=%b exp=0", qa_o);
            end
         end
      end
      checks++;
      if (s1 < 0 || rq - s1 != 2) begin
         errors++;
         $display("FAIL qb_rise_delay got=%0d exp=2", rq - s1);
      end
      checks++;
      if (s2 < 0) begin
         errors++;
         $display("FAIL reach_step2 got=%0d exp=step2_seen", s2);
      end
      kill();
   endtask

   task automatic test_reverse();
      int seq[$];
      int last = -1;
      period_i = 2; dead_i = 1; dir_i = 0; start_i = 1;
      for (int i = 0; i < 60; i++) begin
         tick();
         start_i = 0;
         if (i >= 20) dir_i = 1'($urandom_range(0, 1));
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL reverse cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
         if (i < 20 && busy_o === 1'b1 && int'(step_o) != last) begin
            last = int'(step_o);
            seq.push_back(last);
         end
      end
      checks++;
      if (seq.size() < 4 || seq[0] != 0 || seq[1] != 5 || seq[2] != 4 || seq[3] != 3) begin
         errors++;
         $display("FAIL reverse_order got=%p exp=0,5,4,3", seq);
      end
      kill();
   endtask

   task automatic test_stop_kill();
      int found = 0, held = 0;
      period_i = 9; dead_i = 0; dir_i = 1; start_i = 1;
      for (int i = 0; i < 50 && found == 0; i++) begin
         tick();
         start_i = 0;
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL stop_run cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
         if (step_o == 3'd1) found = 1;
      end
      checks++;
      if (found == 0) begin
         errors++;
         $display("FAIL stop_wait_step1 got=timeout exp=step1");
      end
      tick();                         // second clock of step 1
      stop_i = 1;
      tick();
      stop_i = 0;
      if (busy_o === 1'b1 && {qa_o, qb_o, qc_o} === 3'b110) held++;
      for (int i = 0; i < 11; i++) begin
         tick();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL stopping cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
         if (busy_o === 1'b1 && {qa_o, qb_o, qc_o} === 3'b110) held++;
      end
      checks++;
      if (held != 8 || obs !== 8'h00) begin
         errors++;
         $display("FAIL stop_hold got=%0d/%b exp=8/%b", held, obs, 8'h00);
      end
      start_i = 1;
      for (int i = 0; i < 7; i++) begin
         tick();
         start_i = 0;
      end
      kill();
   endtask

   task automatic test_misc();
      start_i = 1; stop_i = 1; period_i = 3; dead_i = 0;
      tick();
      start_i = 0; stop_i = 0;
      tick();
      checks++;
      if (busy_o !== 1'b0 || obs !== exp_v) begin
         errors++;
         $display("FAIL start_stop_idle got=%b exp=%b", obs, exp_v);
      end
      period_i = 0; dead_i = 0; dir_i = 1; start_i = 1;
      for (int i = 0; i < 14; i++) begin
         tick();
         start_i = 0;
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL period0 cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
      end
      kill();
      period_i = 3; dead_i = 15; start_i = 1;
      for (int i = 0; i < 30; i++) begin
         tick();
         start_i = 0;
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL long_dead cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
      end
      kill();
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         en_i     = ($urandom_range(0, 79) != 0);
         start_i  = ($urandom_range(0, 9) == 0);
         stop_i   = ($urandom_range(0, 39) == 0);
         dir_i    = 1'($urandom_range(0, 1));
         period_i = 16'($urandom_range(0, 5));
         dead_i   = 4'($urandom_range(0, 6));
         tick();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_deadtime();
      test_reverse();
      test_stop_kill();
      test_misc();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
